pipeline_run_controller: RTL and testbench

Sequences execution of the 5-stage MIPS pipeline for the debug unit. It takes the 2-bit run mode issued by the UART debug interface and turns it into a per-cycle global enable for the PC and all inter-stage latches, in either continuous or single-step mode. It detects the HALT instruction at fetch and drains the pipeline. It then reports completion back to the debug interface and keeps a count of executed cycles for the host.

---
 rtl/pipeline_run_controller.sv | 125 ++++++++++++
 tb/tb_pipeline_run_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_run_controller.sv
// rtl/pipeline_run_controller.sv - run/step sequencer for the 5-stage pipeline debug unit
// Turns the debug run mode into a global pipeline enable, drains on HALT, counts enabled cycles.
module pipeline_run_controller #(
  parameter int                        INSTRUCT_WIDTH    = 32,
  parameter logic [5:0]                HALT_OPCODE       = 6'b111111,
  parameter int                        DRAIN_CYCLES      = 4,
  parameter logic [INSTRUCT_WIDTH-1:0] STEP_CMD          = INSTRUCT_WIDTH'(32'h6e657874),
  parameter int                        CYCLE_COUNT_WIDTH = 32
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic [1:0]                   i_start_pipeline,
  input  logic [INSTRUCT_WIDTH-1:0]    i_command,
  input  logic                         i_command_valid,
  input  logic [INSTRUCT_WIDTH-1:0]    i_fetched_instruct,
  output logic                         o_pipeline_enable,
  output logic                         o_pc_freeze,
  output logic                         o_program_finished,
  output logic                         o_step_done,
  output logic [CYCLE_COUNT_WIDTH-1:0] o_cycle_count
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_EXEC = 3'd3,
    FINISHED  = 3'd4
  } state_t;

  state_t                       state;
  logic                         halt_seen;
  logic [DW-1:0]                drain_cnt;
  logic [CYCLE_COUNT_WIDTH-1:0] cycle_count;
  logic                         step_done;

  logic stop;
  logic enable;
  logic is_halt;
  logic step_req;
  logic drain_last;
  logic unused_instr_bits;

  // Mode 10 behaves exactly like 00, so only bit 0 distinguishes stop from go.
  assign stop              = ~i_start_pipeline[0];
  assign enable            = (state == RUN) || (state == STEP_EXEC);
  assign is_halt           = i_fetched_instruct[INSTRUCT_WIDTH-1 -: 6] == HALT_OPCODE;
  assign step_req          = i_command_valid && (i_command == STEP_CMD);
  assign drain_last        = halt_seen && (drain_cnt == DW'(1));
  assign unused_instr_bits = ^i_fetched_instruct[INSTRUCT_WIDTH-7:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      halt_seen   <= 1'b0;
      drain_cnt   <= '0;
      cycle_count <= '0;
      step_done   <= 1'b0;
    end else begin
      step_done <= (state == STEP_EXEC);

      if (enable) begin
        if (cycle_count != '1) cycle_count <= cycle_count + CYCLE_COUNT_WIDTH'(1);
        if (!halt_seen && is_halt) begin
          halt_seen <= 1'b1;
          drain_cnt <= DW'(DRAIN_CYCLES);
        end else if (halt_seen) begin
          drain_cnt <= drain_cnt - DW'(1);
        end
      end

      // Later assignments below override the E-cycle bookkeeping on start/abort.
      case (state)
        IDLE: begin
          if (i_start_pipeline[0]) begin
            state       <= i_start_pipeline[1] ? STEP_WAIT : RUN;
            cycle_count <= '0;
            halt_seen   <= 1'b0;
            drain_cnt   <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state     <= IDLE;
            halt_seen <= 1'b0;
            drain_cnt <= '0;
          end else if (drain_last) begin
            state <= FINISHED;
          end
        end
        STEP_WAIT: begin
          if (stop) begin
            state     <= IDLE;
            halt_seen <= 1'b0;
            drain_cnt <= '0;
          end else if (step_req) begin
            state <= STEP_EXEC;
          end
        end
        STEP_EXEC: begin
          if (stop) begin
            state     <= IDLE;
            halt_seen <= 1'b0;
            drain_cnt <= '0;
          end else begin
            state <= drain_last ? FINISHED : STEP_WAIT;
          end
        end
        FINISHED: begin
          if (stop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_pipeline_enable  = enable;
  assign o_pc_freeze        = halt_seen;
  assign o_program_finished = (state == FINISHED);
  assign o_step_done        = step_done;
  assign o_cycle_count      = cycle_count;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb/tb_pipeline_run_controller.sv - self-checking bench for pipeline_run_controller
// Vector table, directed corner sequences and random stimulus against a behavioural model.
module tb_pipeline_run_controller;

  localparam int          DRAIN = 4;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] HALT  = 32'hFC00_0000;
  localparam logic [31:0] NEXT  = 32'h6e65_7874;
  localparam logic [31:0] CONT  = 32'h636f_6e74;

  logic        clk;
  logic        rst_n;
  logic [1:0]  start;
  logic [31:0] cmd;
  logic        cmd_valid;
  logic [31:0] instr;
  logic        en;
  logic        frz;
  logic        fin;
  logic        done;
  logic [31:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_run_controller dut (
    .i_clk              (clk),
    .i_reset_n          (rst_n),
    .i_start_pipeline   (start),
    .i_command          (cmd),
    .i_command_valid    (cmd_valid),
    .i_fetched_instruct (instr),
    .o_pipeline_enable  (en),
    .o_pc_freeze        (frz),
    .o_program_finished (fin),
    .o_step_done        (done),
    .o_cycle_count      (cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a run is tracked by E-cycle index; finish is halt index + DRAIN.
  bit          m_active, m_step, m_exec, m_fin, m_done;
  int          m_halt_at, m_e;
  logic [31:0] m_count;

  function automatic bit m_en();
    return m_active && (!m_step || m_exec);
  endfunction

  task automatic model_reset();
    m_active = 0; m_step = 0; m_exec = 0; m_fin = 0; m_done = 0;
    m_halt_at = -1; m_e = 0; m_count = 0;
  endtask

  task automatic model_step(input logic [1:0] st, input logic v, input logic [31:0] c,
                            input logic [31:0] ins);
    bit e, stop, reached;
    e       = m_en();
    stop    = !st[0];
    reached = 0;
    m_done  = e && m_step;
    if (m_fin) begin
      if (stop) m_fin = 0;
    end else if (!m_active) begin
      if (st[0]) begin
        m_active = 1; m_step = st[1]; m_exec = 0;
        m_count = 0; m_halt_at = -1; m_e = 0;
      end
    end else begin
      if (e) begin
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        m_e++;
        if (m_halt_at < 0 && ins[31:26] == 6'b111111) m_halt_at = m_e;
        else if (m_halt_at >= 0 && m_e == m_halt_at + DRAIN) reached = 1;
      end
      if (stop) begin
        m_active = 0; m_halt_at = -1; m_exec = 0;
      end else if (reached) begin
        m_active = 0; m_fin = 1; m_exec = 0;
      end else if (m_step) begin
        m_exec = !m_exec && v && (c == NEXT);
      end
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk_b("model_en",   en,   m_en());
    chk_b("model_frz",  frz,  m_halt_at >= 0);
    chk_b("model_fin",  fin,  m_fin);
    chk_b("model_done", done, m_done);
    chk_w("model_cnt",  cnt,  m_count);
  endtask

  // Called just after a falling edge: apply inputs for one cycle, then check at the next fall.
  task automatic drive(input logic [1:0] st, input logic v = 1'b0, input logic [31:0] c = NOP,
                       input logic [31:0] ins = NOP);
    start = st; cmd_valid = v; cmd = c; instr = ins;
    @(posedge clk);
    model_step(st, v, c, ins);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [1:0]  st;
    logic        v;
    logic [31:0] c;
    logic [31:0] ins;
    logic        en;
    logic        frz;
    logic        fin;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int n_en, n_frz, n_done;
    bit seen_low, gap;
    logic [1:0]  rst_st;
    logic        rv;
    logic [31:0] rc, ri;

    clk = 0; rst_n = 0; start = 2'b00; cmd = NOP; cmd_valid = 0; instr = NOP;
    model_reset();

    tbl[0]  = '{2'b01, 1'b0, NOP,  NOP,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{2'b01, 1'b0, NOP,  HALT, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[2]  = '{2'b01, 1'b0, NOP,  NOP,  1'b1, 1'b1, 1'b0, 1'b0, 32'd2};
    tbl[3]  = '{2'b01, 1'b0, NOP,  HALT, 1'b1, 1'b1, 1'b0, 1'b0, 32'd3};
    tbl[4]  = '{2'b01, 1'b0, NOP,  NOP,  1'b1, 1'b1, 1'b0, 1'b0, 32'd4};
    tbl[5]  = '{2'b01, 1'b0, NOP,  NOP,  1'b0, 1'b1, 1'b1, 1'b0, 32'd5};
    tbl[6]  = '{2'b01, 1'b0, NOP,  NOP,  1'b0, 1'b1, 1'b1, 1'b0, 32'd5};
    tbl[7]  = '{2'b00, 1'b0, NOP,  NOP,  1'b0, 1'b1, 1'b0, 1'b0, 32'd5};
    tbl[8]  = '{2'b10, 1'b0, NOP,  NOP,  1'b0, 1'b1, 1'b0, 1'b0, 32'd5};
    tbl[9]  = '{2'b11, 1'b0, NOP,  NOP,  1'b0, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[10] = '{2'b11, 1'b1, NEXT, NOP,  1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    tbl[11] = '{2'b11, 1'b0, NOP,  NOP,  1'b0, 1'b0, 1'b0, 1'b1, 32'd1};
    tbl[12] = '{2'b00, 1'b0, NOP,  NOP,  1'b0, 1'b0, 1'b0, 1'b0, 32'd1};

    @(negedge clk);
    chk_b("reset_en",   en,   1'b0);
    chk_b("reset_frz",  frz,  1'b0);
    chk_b("reset_fin",  fin,  1'b0);
    chk_b("reset_done", done, 1'b0);
    chk_w("reset_cnt",  cnt,  32'd0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].st, tbl[i].v, tbl[i].c, tbl[i].ins);
      chk_b($sformatf("vec%0d_en", i),   en,   tbl[i].en);
      chk_b($sformatf("vec%0d_frz", i),  frz,  tbl[i].frz);
      chk_b($sformatf("vec%0d_fin", i),  fin,  tbl[i].fin);
      chk_b($sformatf("vec%0d_done", i), done, tbl[i].done);
      chk_w($sformatf("vec%0d_cnt", i),  cnt,  tbl[i].cnt);
    end

    // Continuous run, HALT fetched on the 10th E-cycle
    drive(2'b01);
    n_en = int'(en); n_frz = int'(en && frz); seen_low = !en; gap = 0;
    for (int i = 1; i <= 20; i++) begin
      drive(2'b01, 1'b0, NOP, (i == 10) ? HALT : NOP);
      if (en) begin
        if (seen_low) gap = 1;
        n_en++;
        if (frz) n_frz++;
      end else begin
        seen_low = 1;
      end
    end
    chk_w("cont_en_cycles", n_en, 32'd14);
    chk_w("cont_frz_cycles", n_frz, 32'd4);
    chk_b("cont_contiguous", gap, 1'b0);
    chk_b("cont_fin", fin, 1'b1);
    chk_w("cont_cnt", cnt, 32'd14);
    drive(2'b00);
    chk_b("cont_stop_fin", fin, 1'b0);

    // Stepwise: three steps five cycles apart, then an ignored command
    drive(2'b11);
    n_done = 0;
    for (int s = 0; s < 3; s++) begin
      drive(2'b11, 1'b1, NEXT);
      chk_b("step_en", en, 1'b1);
      drive(2'b11);
      chk_b("step_en_off", en, 1'b0);
      if (done) n_done++;
      for (int k = 0; k < 3; k++) begin
        drive(2'b11);
        if (done) n_done++;
        chk_b("step_idle_en", en, 1'b0);
      end
    end
    chk_w("step_done_pulses", n_done, 32'd3);
    drive(2'b11, 1'b1, CONT);
    chk_b("step_cont_ignored", en, 1'b0);
    drive(2'b11);
    chk_w("step_cnt", cnt, 32'd3);

    // Stepwise HALT fetched on step 2
    drive(2'b00);
    drive(2'b11);
    for (int s = 1; s <= 7; s++) begin
      drive(2'b11, 1'b1, NEXT);
      chk_b($sformatf("stepH%0d_en", s), en, s <= 6);
      if (s <= 6) chk_b($sformatf("stepH%0d_frz", s), frz, s >= 3);
      drive(2'b11, 1'b0, NOP, (s == 2) ? HALT : NOP);
      chk_b($sformatf("stepH%0d_fin", s), fin, s >= 6);
      drive(2'b11);
    end

    // Back-to-back step commands
    drive(2'b00);
    drive(2'b11);
    drive(2'b11, 1'b1, NEXT);
    chk_b("b2b_first", en, 1'b1);
    drive(2'b11, 1'b1, NEXT);
    chk_b("b2b_dropped", en, 1'b0);
    drive(2'b11);
    chk_b("b2b_after", en, 1'b0);
    chk_w("b2b_cnt", cnt, 32'd1);

    // Abort after 7 E-cycles, then restart
    drive(2'b00);
    drive(2'b01);
    for (int i = 0; i < 6; i++) drive(2'b01);
    drive(2'b00);
    chk_b("abort_en", en, 1'b0);
    chk_w("abort_cnt", cnt, 32'd7);
    drive(2'b01);
    chk_b("restart_en", en, 1'b1);
    chk_w("restart_cnt", cnt, 32'd0);

    // Asynchronous reset two cycles after HALT fetch
    drive(2'b01, 1'b0, NOP, HALT);
    drive(2'b01);
    drive(2'b01);
    chk_b("pre_rst_frz", frz, 1'b1);
    #2 rst_n = 0;
    #1;
    chk_b("rst_async_en",   en,   1'b0);
    chk_b("rst_async_frz",  frz,  1'b0);
    chk_b("rst_async_fin",  fin,  1'b0);
    chk_b("rst_async_done", done, 1'b0);
    chk_w("rst_async_cnt",  cnt,  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    drive(2'b00);
    chk_b("post_rst_frz", frz, 1'b0);

    // Random stimulus against the model
    rst_st = 2'b01;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) rst_st = 2'($urandom_range(0, 3));
      rv = ($urandom_range(0, 2) == 0);
      rc = ($urandom_range(0, 4) == 0) ? $urandom : NEXT;
      ri = ($urandom_range(0, 7) == 0) ? {6'b111111, 26'($urandom)} : $urandom;
      drive(rst_st, rv, rc, ri);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
